// File: rtl/fm_discriminator.sv
// Iterative CORDIC FM discriminator: vectors each I/Q sample to an angle in turns
// and outputs the wrapped angle difference from the previous sample.
module fm_discriminator #(
    parameter int NBITS_IQ    = 16,
    parameter int NBITS_PHASE = 32,
    parameter int NITER       = 16
) (
    input  logic                          i_clock,
    input  logic                          i_reset_n,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    input  logic signed [NBITS_IQ-1:0]    i_in_i,
    input  logic signed [NBITS_IQ-1:0]    i_in_q,
    output logic        [NBITS_PHASE-1:0] o_phaseinc,
    output logic                          o_out_valid
);

    localparam int XW = NBITS_IQ + 2;
    localparam int KW = (NITER > 1) ? $clog2(NITER) : 1;

    // Elaboration-time arctangent in turns, using a power series so no math library is needed.
    function automatic logic [NBITS_PHASE-1:0] atanConst(input int k);
        real pi;
        real x;
        real xPow;
        real rad;
        real turns;
        pi  = 3.14159265358979323846;
        rad = 0.0;
        if (k == 0) begin
            rad = pi / 4.0;
        end else begin
            x    = 1.0 / (2.0 ** k);
            xPow = x;
            for (int n = 0; n < 40; n++) begin
                if (n % 2 == 0) rad = rad + xPow / real'(2 * n + 1);
                else            rad = rad - xPow / real'(2 * n + 1);
                xPow = xPow * x * x;
            end
        end
        turns = rad / (2.0 * pi);
        return NBITS_PHASE'(longint'(turns * (2.0 ** NBITS_PHASE)));
    endfunction

    typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

    state_t                       r_state;
    state_t                       w_nextState;
    logic signed [XW-1:0]         r_x;
    logic signed [XW-1:0]         r_y;
    logic [NBITS_PHASE-1:0]       r_z;
    logic [KW-1:0]                r_k;
    logic                         r_zero;
    logic                         r_primed;
    logic [NBITS_PHASE-1:0]       r_prevAngle;
    logic [NBITS_PHASE-1:0]       r_phaseinc;
    logic                         r_outValid;

    logic [NBITS_PHASE-1:0]       w_atanTable [NITER];
    logic [NBITS_PHASE-1:0]       w_atan;
    logic signed [XW-1:0]         w_iExt;
    logic signed [XW-1:0]         w_qExt;
    logic signed [XW-1:0]         w_xShift;
    logic signed [XW-1:0]         w_yShift;
    logic [NBITS_PHASE-1:0]       w_angle;
    logic                         w_lastIter;

    for (genvar g = 0; g < NITER; g++) begin : g_atan
        localparam logic [NBITS_PHASE-1:0] ATAN_K = atanConst(g);
        assign w_atanTable[g] = ATAN_K;
    end

    // Two guard bits absorb the negation of the most negative input and the CORDIC gain.
    assign w_iExt     = {{2{i_in_i[NBITS_IQ-1]}}, i_in_i};
    assign w_qExt     = {{2{i_in_q[NBITS_IQ-1]}}, i_in_q};
    assign w_xShift   = r_x >>> r_k;
    assign w_yShift   = r_y >>> r_k;
    assign w_atan     = w_atanTable[r_k];
    assign w_lastIter = (r_k == KW'(NITER - 1));
    assign w_angle    = r_zero ? r_prevAngle : r_z;

    assign o_in_ready  = (r_state == IDLE);
    assign o_phaseinc  = r_phaseinc;
    assign o_out_valid = r_outValid;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= IDLE;
        else            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (i_in_valid) w_nextState = ROT;
            ROT:     if (w_lastIter) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_k         <= '0;
            r_zero      <= 1'b0;
            r_primed    <= 1'b0;
            r_prevAngle <= '0;
            r_phaseinc  <= '0;
            r_outValid  <= 1'b0;
        end else begin
            r_outValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        // Left half-plane vectors are folded by a half turn so rotations converge.
                        if (w_iExt[XW-1]) begin
                            r_x <= -w_iExt;
                            r_y <= -w_qExt;
                            r_z <= {1'b1, {(NBITS_PHASE-1){1'b0}}};
                        end else begin
                            r_x <= w_iExt;
                            r_y <= w_qExt;
                            r_z <= '0;
                        end
                        r_zero <= (i_in_i == '0) && (i_in_q == '0);
                        r_k    <= '0;
                    end
                end
                ROT: begin
                    if (!r_y[XW-1]) begin
                        r_x <= r_x + w_yShift;
                        r_y <= r_y - w_xShift;
                        r_z <= r_z + w_atan;
                    end else begin
                        r_x <= r_x - w_yShift;
                        r_y <= r_y + w_xShift;
                        r_z <= r_z - w_atan;
                    end
                    r_k <= r_k + 1'b1;
                end
                DONE: begin
                    if (r_primed) begin
                        r_phaseinc <= w_angle - r_prevAngle;
                        r_outValid <= 1'b1;
                    end
                    r_primed    <= 1'b1;
                    r_prevAngle <= w_angle;
                end
                default: ;
            endcase
        end
    end

endmodule
